fifo_rd_consumer: RTL and testbench
===================================

Name: fifo_rd_consumer

Overview:
- Parametrised read-side consumer for the asynchronous FIFO. Sits in the clk2 (read) domain and drives Read against the FIFO's Empty and Data_out.
- Next generation of the basic consumer: adds start/stop control, continuous/burst/throttled drain modes, and correct one-cycle read-latency handling.
- Also adds a local capture buffer with readback, received-word counting, and an incrementing-sequence checker for end-to-end FIFO verification.

Parameters:
- WIDTH, 32, FIFO data word width in bits.
- DEPTH, 512, capture-buffer entries; must be a power of two.
- PTR_WIDTH, $clog2(DEPTH), capture pointer and readback address width.
- CNT_WIDTH, 16, width of Burst_len, Gap and Rx_count.

Ports:
- clk2  in  1  read-domain clock.
- rst_n  in  1  asynchronous active-low reset.
- Empty  in  1  FIFO empty flag, synchronous to clk2.
- Data_out  in  WIDTH  FIFO read data; valid the cycle after a Read with Empty low.
- Read  out  1  FIFO read enable.
- Mode  in  2  0 idle, 1 continuous, 2 burst, 3 throttled; sampled on Start.
- Start  in  1  single-cycle pulse that begins an operation.
- Stop  in  1  single-cycle pulse that ends continuous/throttled operation.
- Burst_len  in  CNT_WIDTH  number of reads in burst mode; sampled on Start.
- Gap  in  CNT_WIDTH  idle cycles between reads in throttled mode; sampled on Start.
- Check_en  in  1  enables the incrementing-sequence check.
- Busy  out  1  high while not in IDLE.
- Done  out  1  one-cycle pulse when an operation completes.
- Rx_count  out  CNT_WIDTH  words captured since the last Start; saturates at all-ones.
- Cap_full  out  1  capture buffer holds DEPTH words.
- Err  out  1  sticky sequence mismatch.
- Cap_addr  in  PTR_WIDTH  readback address.
- Cap_data  out  WIDTH  registered readback data.

Behaviour:
- Reset (async assert, sync release): all outputs are 0 and the FSM is in IDLE. Pointers, counters, the issued-count and the expected register are cleared. Capture memory contents are not reset.
- FSM states: IDLE, RUN, GAP, DRAIN.
- IDLE:
  - Start with Mode != 0 latches Mode/Burst_len/Gap, clears wr_ptr, Rx_count, Cap_full, Err and issued-count, then goes to RUN.
  - Start with Mode 0 is ignored.
  - Start with Mode 2 and Burst_len 0 goes directly to DRAIN, which produces Done after one cycle.
- Read = (state == RUN) && !Empty && (issued < DEPTH). Read is never asserted while Empty is high; Data_out is never captured on an empty read.
- Read latency:
  - rd_vld is Read delayed one cycle.
  - When rd_vld is high, mem[wr_ptr] <= Data_out, wr_ptr increments, and Rx_count increments.
  - issued increments on Read, so in-flight words are counted and the buffer never overflows.
- RUN transitions:
  - Mode 2: after the Burst_len-th Read, go to DRAIN.
  - Mode 3: after every Read, go to GAP if Gap > 0; with Gap 0 this behaves like continuous.
  - Mode 1/3: Stop goes to DRAIN.
  - Any mode: issued reaching DEPTH goes to DRAIN.
- GAP: counts Gap cycles, then returns to RUN. Stop in GAP goes to DRAIN.
- DRAIN: waits until rd_vld is low (the last word has been captured), pulses Done for one cycle, then returns to IDLE.
- Stop arriving in the same cycle as a Read: that Read completes and its word is captured.
- Cap_full sets when the DEPTH-th word is written. wr_ptr does not wrap within an operation.
- Sequence checker:
  - Applies when Check_en is high and rd_vld is high.
  - The first captured word after Start seeds expected = word + 1.
  - Each later word must equal expected, with modulo 2^WIDTH wrap.
  - On mismatch, Err sets and stays set until the next Start, and expected re-seeds from the received word.
- Readback: Cap_data <= mem[Cap_addr] every clk2 edge, giving 1-cycle latency. Readback is legal at any time. Reading an entry in the same cycle it is written returns the old data.
- Reset mid-operation: the block returns to IDLE immediately and Read drops asynchronously. An in-flight word is discarded.

Decomposition:
- Package fifo_pkg: WIDTH/DEPTH defaults, the mode_e enum (MODE_IDLE, MODE_CONT, MODE_BURST, MODE_THROT), and the state_e enum.
- Sub-module cap_ram: single-port-write / registered-read memory of DEPTH x WIDTH. It is instantiated once and keeps the RAM inferable.

Test Plan:
- Burst: FIFO preloaded with 0..9, Mode 2, Burst_len 8 → exactly 8 Read cycles, Done 1 cycle after the last capture, Rx_count 8, Cap_data at addr 7 = 7, Err 0.
- Empty gating: Mode 1, FIFO empty 5 cycles then words 100..103 pushed, then Stop → Read stays low while Empty, Rx_count 4, and Done follows Stop after the in-flight word is captured.
- Throttle: Mode 3, Gap 3, FIFO holding 4 words → Read is high once every 4 cycles, then Stop → Rx_count 4.
- Overflow guard: DEPTH 8, Mode 1, FIFO holding 20 words → exactly 8 Reads, Cap_full 1, Done asserted without Stop.
- Sequence error: Check_en 1, stream 5,6,7,9,10 → Err sets on the cycle 9 is captured, stays 1 through 10, and clears on the next Start.
- Reset mid-burst: rst_n asserted during RUN with Burst_len 16 → Read, Busy and Done go to 0 immediately; a fresh Start after release begins with Rx_count 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and enums for the FIFO read-side consumer
package fifo_pkg;

   localparam int FIFO_WIDTH     = 32;
   localparam int FIFO_DEPTH     = 512;
   localparam int FIFO_CNT_WIDTH = 16;

   typedef enum logic [1:0] {
      MODE_IDLE  = 2'd0,
      MODE_CONT  = 2'd1,
      MODE_BURST = 2'd2,
      MODE_THROT = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_GAP   = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

endpackage

// File: rtl/cap_ram.sv
// rtl/cap_ram.sv - DEPTH x WIDTH capture memory, one write port and a registered read port
module cap_ram #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 512,
   parameter int PTR_WIDTH = $clog2(DEPTH)
) (
   input  logic                 clk2,
   input  logic                 rst_n,
   input  logic                 we,
   input  logic [PTR_WIDTH-1:0] waddr,
   input  logic [WIDTH-1:0]     wdata,
   input  logic [PTR_WIDTH-1:0] raddr,
   output logic [WIDTH-1:0]     rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Array write kept free of reset so the storage maps onto block RAM
   always_ff @(posedge clk2) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered readback; a same-cycle write to raddr returns the old word
   always_ff @(posedge clk2 or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/fifo_rd_consumer.sv
// rtl/fifo_rd_consumer.sv - read-domain FIFO consumer with drain modes, capture buffer and sequence check
module fifo_rd_consumer
   import fifo_pkg::*;
#(
   parameter int WIDTH     = FIFO_WIDTH,
   parameter int DEPTH     = FIFO_DEPTH,
   parameter int PTR_WIDTH = $clog2(DEPTH),
   parameter int CNT_WIDTH = FIFO_CNT_WIDTH
) (
   input  logic                 clk2,
   input  logic                 rst_n,
   input  logic                 Empty,
   input  logic [WIDTH-1:0]     Data_out,
   output logic                 Read,
   input  logic [1:0]           Mode,
   input  logic                 Start,
   input  logic                 Stop,
   input  logic [CNT_WIDTH-1:0] Burst_len,
   input  logic [CNT_WIDTH-1:0] Gap,
   input  logic                 Check_en,
   output logic                 Busy,
   output logic                 Done,
   output logic [CNT_WIDTH-1:0] Rx_count,
   output logic                 Cap_full,
   output logic                 Err,
   input  logic [PTR_WIDTH-1:0] Cap_addr,
   output logic [WIDTH-1:0]     Cap_data
);

   // issued counts up to DEPTH inclusive, so it needs one bit more than the pointer
   localparam int                 ISS_W   = PTR_WIDTH + 1;
   localparam logic [ISS_W-1:0]   ISS_MAX = ISS_W'(DEPTH);

   state_e                 state;
   mode_e                  mode_q;
   logic [CNT_WIDTH-1:0]   burst_len_q;
   logic [CNT_WIDTH-1:0]   gap_q;
   logic [CNT_WIDTH-1:0]   gap_cnt;
   logic [ISS_W-1:0]       issued;
   logic [ISS_W-1:0]       issued_nxt;
   logic [PTR_WIDTH-1:0]   wr_ptr;
   logic                   rd_vld;
   logic                   seeded;
   logic [WIDTH-1:0]       expected;
   logic                   start_op;
   logic                   stop_mode;
   logic                   burst_hit;
   logic                   depth_hit;

   assign start_op   = (state == ST_IDLE) && Start && (Mode != MODE_IDLE);
   assign stop_mode  = Stop && ((mode_q == MODE_CONT) || (mode_q == MODE_THROT));
   assign issued_nxt = issued + ISS_W'(1);
   assign burst_hit  = (mode_q == MODE_BURST) &&
                       ({{CNT_WIDTH{1'b0}}, issued_nxt} == {{ISS_W{1'b0}}, burst_len_q});
   assign depth_hit  = (issued_nxt == ISS_MAX);

   // In-flight reads are counted in issued, which keeps the capture buffer from overflowing
   assign Read = (state == ST_RUN) && !Empty && (issued < ISS_MAX);
   assign Busy = (state != ST_IDLE);

   // Operation sequencing: launch, pacing of reads, and completion after the last capture
   always_ff @(posedge clk2 or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         mode_q      <= MODE_IDLE;
         burst_len_q <= '0;
         gap_q       <= '0;
         gap_cnt     <= '0;
         issued      <= '0;
         Done        <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_op) begin
                  mode_q      <= mode_e'(Mode);
                  burst_len_q <= Burst_len;
                  gap_q       <= Gap;
                  issued      <= '0;
                  if ((mode_e'(Mode) == MODE_BURST) && (Burst_len == '0)) begin
                     state <= ST_DRAIN;
                  end else begin
                     state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (Read) begin
                  issued <= issued_nxt;
                  if (burst_hit || depth_hit || stop_mode) begin
                     state <= ST_DRAIN;
                  end else if ((mode_q == MODE_THROT) && (gap_q != '0)) begin
                     state   <= ST_GAP;
                     gap_cnt <= '0;
                  end
               end else if (stop_mode) begin
                  state <= ST_DRAIN;
               end
            end
            ST_GAP: begin
               if (stop_mode) begin
                  state <= ST_DRAIN;
               end else if (gap_cnt == gap_q - CNT_WIDTH'(1)) begin
                  state <= ST_RUN;
               end else begin
                  gap_cnt <= gap_cnt + CNT_WIDTH'(1);
               end
            end
            ST_DRAIN: begin
               if (!rd_vld) begin
                  Done  <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Capture side: word arrives one cycle after Read; count it, flag full, check sequence
   always_ff @(posedge clk2 or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld   <= 1'b0;
         wr_ptr   <= '0;
         Rx_count <= '0;
         Cap_full <= 1'b0;
         Err      <= 1'b0;
         seeded   <= 1'b0;
         expected <= '0;
      end else begin
         rd_vld <= Read;
         if (start_op) begin
            wr_ptr   <= '0;
            Rx_count <= '0;
            Cap_full <= 1'b0;
            Err      <= 1'b0;
            seeded   <= 1'b0;
         end else if (rd_vld) begin
            wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (Rx_count != '1) begin
               Rx_count <= Rx_count + CNT_WIDTH'(1);
            end
            if (wr_ptr == PTR_WIDTH'(DEPTH - 1)) begin
               Cap_full <= 1'b1;
            end
            if (Check_en) begin
               // Mismatch or not, the next expected word follows the one just received
               seeded   <= 1'b1;
               expected <= Data_out + WIDTH'(1);
               if (seeded && (Data_out != expected)) begin
                  Err <= 1'b1;
               end
            end
         end
      end
   end

   cap_ram #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .PTR_WIDTH (PTR_WIDTH)
   ) u_cap_ram (
      .clk2  (clk2),
      .rst_n (rst_n),
      .we    (rd_vld),
      .waddr (wr_ptr),
      .wdata (Data_out),
      .raddr (Cap_addr),
      .rdata (Cap_data)
   );

endmodule

// File: tb/tb_fifo_rd_consumer.sv
// tb/tb_fifo_rd_consumer.sv - self-checking bench for fifo_rd_consumer
module tb_fifo_rd_consumer;

   localparam int W  = 8;
   localparam int D  = 8;
   localparam int PW = 3;
   localparam int CW = 8;

   logic          clk2 = 1'b0;
   logic          rst_n;
   logic          Empty;
   logic [W-1:0]  Data_out = '0;
   logic          Read;
   logic [1:0]    Mode;
   logic          Start;
   logic          Stop;
   logic [CW-1:0] Burst_len;
   logic [CW-1:0] Gap;
   logic          Check_en;
   logic          Busy;
   logic          Done;
   logic [CW-1:0] Rx_count;
   logic          Cap_full;
   logic          Err;
   logic [PW-1:0] Cap_addr;
   logic [W-1:0]  Cap_data;

   int errors = 0;
   int checks = 0;

   // FIFO model: array plus indices; pops on a sampled Read, data valid next cycle
   logic [W-1:0] fmem [0:1023];
   int           wr_idx = 0;
   int           rd_idx = 0;
   int           underflow = 0;
   int           cyc = 0;

   // Monitor state
   int           read_cnt = 0;
   int           read_cyc[$];
   int           done_cnt = 0;
   int           done_cyc = 0;
   logic         err_log[$];
   logic [CW-1:0] prev_rx = '0;

   assign Empty = (wr_idx == rd_idx);

   always #5 clk2 = ~clk2;

   fifo_rd_consumer #(
      .WIDTH     (W),
      .DEPTH     (D),
      .PTR_WIDTH (PW),
      .CNT_WIDTH (CW)
   ) dut (
      .clk2      (clk2),
      .rst_n     (rst_n),
      .Empty     (Empty),
      .Data_out  (Data_out),
      .Read      (Read),
      .Mode      (Mode),
      .Start     (Start),
      .Stop      (Stop),
      .Burst_len (Burst_len),
      .Gap       (Gap),
      .Check_en  (Check_en),
      .Busy      (Busy),
      .Done      (Done),
      .Rx_count  (Rx_count),
      .Cap_full  (Cap_full),
      .Err       (Err),
      .Cap_addr  (Cap_addr),
      .Cap_data  (Cap_data)
   );

   always @(posedge clk2) begin
      cyc <= cyc + 1;
      if (Read) begin
         if (Empty) begin
            underflow <= underflow + 1;
         end else begin
            Data_out <= fmem[rd_idx & 1023];
            rd_idx   <= rd_idx + 1;
         end
      end
   end

   always @(negedge clk2) begin
      if (Read) begin
         read_cnt++;
         read_cyc.push_back(cyc);
      end
      if (Done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (Rx_count != prev_rx) begin
         if (Rx_count != '0) err_log.push_back(Err);
         prev_rx = Rx_count;
      end
   end

   task automatic tick();
      @(posedge clk2);
      #1;
   endtask

   task automatic push(input logic [W-1:0] v);
      fmem[wr_idx & 1023] = v;
      wr_idx++;
   endtask

   task automatic flush();
      wr_idx = rd_idx;
   endtask

   task automatic clear_mon();
      read_cnt = 0;
      read_cyc.delete();
      done_cnt = 0;
      done_cyc = 0;
      err_log.delete();
   endtask

   task automatic start_op(input logic [1:0] m, input int bl, input int g, input logic ce);
      Mode      = m;
      Burst_len = CW'(bl);
      Gap       = CW'(g);
      Check_en  = ce;
      Start     = 1'b1;
      tick();
      Start     = 1'b0;
   endtask

   task automatic pulse_stop();
      Stop = 1'b1;
      tick();
      Stop = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk2);
         if (done_cnt > 0) begin
            ok = 1'b1;
            break;
         end
      end
      tick();
   endtask

   task automatic wait_reads(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk2);
         if (read_cnt >= n) begin
            ok = 1'b1;
            break;
         end
      end
      tick();
   endtask

   task automatic readback(input int addr, output logic [W-1:0] d);
      Cap_addr = PW'(addr);
      tick();
      d = Cap_data;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      checks++;
      if ({Read, Busy, Done, Cap_full, Err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 00000", {Read, Busy, Done, Cap_full, Err});
      end
      checks++;
      if (Rx_count !== '0 || Cap_data !== '0) begin
         errors++;
         $display("FAIL reset_counts: got rx=%0d cap=%0d expected 0/0", Rx_count, Cap_data);
      end
      rst_n = 1'b1;
      tick();
      clear_mon();
      start_op(2'd0, 5, 0, 1'b0);
      tick();
      checks++;
      if (Busy !== 1'b0 || done_cnt != 0) begin
         errors++;
         $display("FAIL mode0_ignored: got busy=%b done=%0d expected 0/0", Busy, done_cnt);
      end
   endtask

   task automatic run_burst(input int start_v, input int navail, input int blen, input string tag);
      logic [W-1:0] words[$];
      logic [W-1:0] d;
      int           exp_n;
      bit           ok;
      flush();
      for (int i = 0; i < navail; i++) begin
         words.push_back(W'(start_v + i));
         push(W'(start_v + i));
      end
      exp_n = blen;
      if (navail < exp_n) exp_n = navail;
      if (D < exp_n) exp_n = D;
      clear_mon();
      start_op(2'd2, blen, 0, 1'b1);
      wait_done(80, ok);
      tick();
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_timeout: got no Done expected Done", tag);
      end
      checks++;
      if (read_cnt != exp_n || done_cnt != 1) begin
         errors++;
         $display("FAIL %s_reads: got reads=%0d dones=%0d expected %0d/1", tag, read_cnt, done_cnt, exp_n);
      end
      checks++;
      if (Rx_count !== CW'(exp_n) || Cap_full !== (exp_n == D) || Err !== 1'b0 || Busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_status: got rx=%0d full=%b err=%b busy=%b expected %0d/%b/0/0",
                  tag, Rx_count, Cap_full, Err, Busy, exp_n, (exp_n == D));
      end
      if (exp_n > 0 && read_cyc.size() > 0) begin
         checks++;
         if (done_cyc - read_cyc[read_cyc.size()-1] != 3) begin
            errors++;
            $display("FAIL %s_done_timing: got %0d expected 3", tag, done_cyc - read_cyc[read_cyc.size()-1]);
         end
      end
      for (int i = 0; i < exp_n; i++) begin
         readback(i, d);
         checks++;
         if (d !== words[i]) begin
            errors++;
            $display("FAIL %s_cap[%0d]: got %0d expected %0d", tag, i, d, words[i]);
         end
      end
      flush();
   endtask

   task automatic test_burst();
      int blen;
      int need;
      run_burst(0, 10, 8, "burst");
      for (int t = 0; t < 4; t++) begin
         blen = (t == 0) ? 0 : int'($urandom_range(1, 10));
         need = (blen < D) ? blen : D;
         run_burst(int'($urandom_range(0, 255)), need + int'($urandom_range(0, 3)), blen, "burst_rand");
      end
   endtask

   task automatic test_empty_gating();
      logic [W-1:0] d;
      bit           ok;
      flush();
      clear_mon();
      start_op(2'd1, 0, 0, 1'b0);
      repeat (5) tick();
      checks++;
      if (read_cnt != 0 || Busy !== 1'b1) begin
         errors++;
         $display("FAIL gate_empty: got reads=%0d busy=%b expected 0/1", read_cnt, Busy);
      end
      for (int i = 0; i < 4; i++) push(W'(100 + i));
      wait_reads(4, 20, ok);
      Stop = 1'b1;
      tick();
      Stop = 1'b0;
      wait_done(20, ok);
      checks++;
      if (!ok || read_cnt != 4 || Rx_count !== CW'(4) || underflow != 0) begin
         errors++;
         $display("FAIL gate_result: got done=%b reads=%0d rx=%0d uflow=%0d expected 1/4/4/0",
                  ok, read_cnt, Rx_count, underflow);
      end
      for (int i = 0; i < 4; i++) begin
         readback(i, d);
         checks++;
         if (d !== W'(100 + i)) begin
            errors++;
            $display("FAIL gate_cap[%0d]: got %0d expected %0d", i, d, 100 + i);
         end
      end
   endtask

   task automatic test_stop_with_read();
      logic [W-1:0] d;
      bit           ok;
      logic         rd_at_stop;
      flush();
      for (int i = 0; i < 6; i++) push(W'(40 + i));
      clear_mon();
      start_op(2'd1, 0, 0, 1'b1);
      tick();
      tick();
      rd_at_stop = Read;
      Stop = 1'b1;
      tick();
      Stop = 1'b0;
      wait_done(20, ok);
      checks++;
      if (!ok || rd_at_stop !== 1'b1 || read_cnt != 3 || Rx_count !== CW'(3)) begin
         errors++;
         $display("FAIL stop_read: got done=%b rd=%b reads=%0d rx=%0d expected 1/1/3/3",
                  ok, rd_at_stop, read_cnt, Rx_count);
      end
      readback(2, d);
      checks++;
      if (d !== W'(42)) begin
         errors++;
         $display("FAIL stop_read_cap: got %0d expected 42", d);
      end
      flush();
   endtask

   task automatic run_throttle(input int g, input int n);
      bit ok;
      int bad;
      flush();
      for (int i = 0; i < n; i++) push(W'(i));
      clear_mon();
      start_op(2'd3, 0, g, 1'b0);
      wait_reads(n, (g + 1) * n + 10, ok);
      pulse_stop();
      wait_done(20, ok);
      bad = 0;
      for (int i = 1; i < read_cyc.size(); i++) begin
         if (read_cyc[i] - read_cyc[i-1] != g + 1) bad++;
      end
      checks++;
      if (!ok || bad != 0 || read_cnt != n) begin
         errors++;
         $display("FAIL throttle_gap%0d: got done=%b bad_spacing=%0d reads=%0d expected 1/0/%0d",
                  g, ok, bad, read_cnt, n);
      end
      checks++;
      if (Rx_count !== CW'(n)) begin
         errors++;
         $display("FAIL throttle_rx_gap%0d: got %0d expected %0d", g, Rx_count, n);
      end
      flush();
   endtask

   task automatic test_throttle();
      run_throttle(3, 4);
      run_throttle(0, 5);
      run_throttle(int'($urandom_range(1, 5)), 5);
   endtask

   task automatic test_overflow();
      logic [W-1:0] d;
      bit           ok;
      flush();
      for (int i = 0; i < 20; i++) push(W'(200 + i));
      clear_mon();
      start_op(2'd1, 0, 0, 1'b0);
      wait_done(60, ok);
      checks++;
      if (!ok || read_cnt != D || Cap_full !== 1'b1 || Rx_count !== CW'(D)) begin
         errors++;
         $display("FAIL overflow: got done=%b reads=%0d full=%b rx=%0d expected 1/%0d/1/%0d",
                  ok, read_cnt, Cap_full, Rx_count, D, D);
      end
      readback(D - 1, d);
      checks++;
      if (d !== W'(200 + D - 1)) begin
         errors++;
         $display("FAIL overflow_cap: got %0d expected %0d", d, 200 + D - 1);
      end
      flush();
   endtask

   task automatic run_seq(input logic [W-1:0] words[$], input logic ce, input string tag);
      int           n;
      bit           ok;
      logic         exp_err;
      logic [W-1:0] nxt;
      n = words.size();
      flush();
      foreach (words[i]) push(words[i]);
      clear_mon();
      start_op(2'd2, n, 0, ce);
      wait_done(60, ok);
      checks++;
      if (!ok || err_log.size() != n) begin
         errors++;
         $display("FAIL %s_len: got done=%b captures=%0d expected 1/%0d", tag, ok, err_log.size(), n);
      end
      exp_err = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            nxt = words[i-1] + W'(1);
            if (ce && words[i] !== nxt) exp_err = 1'b1;
         end
         if (i < err_log.size()) begin
            checks++;
            if (err_log[i] !== exp_err) begin
               errors++;
               $display("FAIL %s_err[%0d]: got %b expected %b", tag, i, err_log[i], exp_err);
            end
         end
      end
      flush();
   endtask

   task automatic test_sequence();
      logic [W-1:0] words[$];
      logic [W-1:0] v;
      int           n;
      bit           ok;
      words = '{8'd5, 8'd6, 8'd7, 8'd9, 8'd10};
      run_seq(words, 1'b1, "seq_gap");
      flush();
      push(W'(0));
      clear_mon();
      start_op(2'd2, 1, 0, 1'b1);
      checks++;
      if (Err !== 1'b0) begin
         errors++;
         $display("FAIL seq_clear_on_start: got %b expected 0", Err);
      end
      wait_done(20, ok);
      words = '{8'd254, 8'd255, 8'd0, 8'd1, 8'd2};
      run_seq(words, 1'b1, "seq_wrap");
      words = '{8'd1, 8'd2, 8'd50, 8'd51};
      run_seq(words, 1'b0, "seq_disabled");
      for (int t = 0; t < 3; t++) begin
         words.delete();
         n = int'($urandom_range(3, 8));
         v = W'($urandom);
         for (int i = 0; i < n; i++) begin
            if (i > 0) v = ($urandom_range(0, 3) == 0) ? W'($urandom) : v + W'(1);
            words.push_back(v);
         end
         run_seq(words, 1'b1, "seq_rand");
      end
   endtask

   task automatic test_reset_mid();
      bit   ok;
      logic rd_before;
      flush();
      for (int i = 0; i < 16; i++) push(W'(i));
      clear_mon();
      start_op(2'd2, 16, 0, 1'b0);
      repeat (3) tick();
      rd_before = Read;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (rd_before !== 1'b1 || Read !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got rd_before=%b read=%b busy=%b done=%b expected 1/0/0/0",
                  rd_before, Read, Busy, Done);
      end
      tick();
      rst_n = 1'b1;
      flush();
      tick();
      for (int i = 0; i < 3; i++) push(W'(30 + i));
      clear_mon();
      start_op(2'd2, 3, 0, 1'b1);
      checks++;
      if (Rx_count !== '0) begin
         errors++;
         $display("FAIL reset_restart_rx0: got %0d expected 0", Rx_count);
      end
      wait_done(30, ok);
      checks++;
      if (!ok || Rx_count !== CW'(3) || Err !== 1'b0) begin
         errors++;
         $display("FAIL reset_restart: got done=%b rx=%0d err=%b expected 1/3/0", ok, Rx_count, Err);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      Start     = 1'b0;
      Stop      = 1'b0;
      Mode      = 2'd0;
      Burst_len = '0;
      Gap       = '0;
      Check_en  = 1'b0;
      Cap_addr  = '0;
      test_reset();
      test_burst();
      test_empty_gating();
      test_stop_with_read();
      test_throttle();
      test_overflow();
      test_sequence();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
